// File: rtl/spdif_pkg.sv
// Shared types and slot-map constants for the S/PDIF frame sequencer.
package spdif_pkg;

  typedef enum logic [1:0] {
    PRE_B = 2'd0,
    PRE_M = 2'd1,
    PRE_W = 2'd2
  } pre_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  localparam int SLOTS  = 32;
  localparam int FRAMES = 192;

  localparam logic [4:0] SLOT_AUX = 5'd4;
  localparam logic [4:0] SLOT_AUD = 5'd8;
  localparam logic [4:0] SLOT_V   = 5'd28;
  localparam logic [4:0] SLOT_U   = 5'd29;
  localparam logic [4:0] SLOT_C   = 5'd30;
  localparam logic [4:0] SLOT_P   = 5'd31;

endpackage

// File: rtl/spdif_sample_buf.sv
// One-entry holding register for an L/R sample pair: valid/ready on the
// producer side, a single-cycle consume strobe on the sequencer side.
module spdif_sample_buf
  import spdif_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk1,
  input  logic             nrst,
  input  logic [WIDTH-1:0] l_in,
  input  logic [WIDTH-1:0] r_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             consume,
  output logic             full,
  output logic [WIDTH-1:0] l_out,
  output logic [WIDTH-1:0] r_out
);

  logic load;

  assign in_ready = !full;
  assign load     = in_valid && !full;

  // A load in the consume cycle keeps the register full with the new pair.
  always_ff @(posedge clk1 or negedge nrst) begin
    if (!nrst) begin
      full  <= 1'b0;
      l_out <= '0;
      r_out <= '0;
    end else begin
      if (load) begin
        l_out <= l_in;
        r_out <= r_in;
      end
      full <= load || (full && !consume);
    end
  end

endmodule

// File: rtl/spdif_frame_sequencer.sv
// S/PDIF subframe/frame/block sequencer feeding the biphase-mark encoder.
// Optional SPDIF_UNDERRUN_HOLD_EN: underrun filler repeats the last consumed pair.
module spdif_frame_sequencer
  import spdif_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CS_W  = 32
) (
  input  logic             clk1,
  input  logic             nrst,
  input  logic             bit_en,
  input  logic             en,
  input  logic [WIDTH-1:0] l_sample,
  input  logic [WIDTH-1:0] r_sample,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [CS_W-1:0]  cs_bits,
  output logic             slot_valid,
  output logic             slot_bit,
  output logic             slot_pre,
  output logic [1:0]       pre_type,
  output logic [7:0]       frame_idx,
  output logic             underrun,
  input  logic             underrun_clr
);

  localparam int AUX_BITS = int'(SLOT_AUD) - int'(SLOT_AUX);
  localparam int AUD_BITS = int'(SLOT_V) - int'(SLOT_AUD);
  localparam int PAD      = AUX_BITS + AUD_BITS - WIDTH;

  seq_state_t       state, state_d;
  logic [4:0]       slot;
  logic             ch_b;
  logic [7:0]       frame;
  logic             emit, last_slot, consume, underrun_evt, go_idle;
  logic             buf_full;
  logic [WIDTH-1:0] buf_l, buf_r;
  logic [WIDTH-1:0] cur_l, cur_r;
  logic             cur_v, cur_c, par;
  logic [23:0]      word;
  logic [CS_W-1:0]  cs_mask;
  logic             cs_bit, bit_d;
  pre_t             pre_d;

  assign emit         = bit_en && (state != ST_IDLE);
  assign last_slot    = ch_b && (slot == 5'(SLOTS - 1));
  assign consume      = emit && !ch_b && (slot == '0);
  assign underrun_evt = consume && !buf_full;
  assign go_idle      = (state != ST_IDLE) && (state_d == ST_IDLE);

  spdif_sample_buf #(.WIDTH(WIDTH)) u_buf (
    .clk1     (clk1),
    .nrst     (nrst),
    .l_in     (l_sample),
    .r_in     (r_sample),
    .in_valid (sample_valid),
    .in_ready (sample_ready),
    .consume  (consume),
    .full     (buf_full),
    .l_out    (buf_l),
    .r_out    (buf_r)
  );

  always_ff @(posedge clk1 or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Dropping en only stops the sequencer once the current frame has finished.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (bit_en && en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = (emit && last_slot) ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (en)                     state_d = ST_RUN;
        else if (emit && last_slot) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge nrst) begin
    if (!nrst) begin
      slot  <= '0;
      ch_b  <= 1'b0;
      frame <= '0;
    end else if (go_idle) begin
      slot  <= '0;
      ch_b  <= 1'b0;
      frame <= '0;
    end else if (emit) begin
      if (slot == 5'(SLOTS - 1)) begin
        slot <= '0;
        ch_b <= !ch_b;
        if (ch_b) frame <= (frame == 8'(FRAMES - 1)) ? '0 : frame + 8'd1;
      end else begin
        slot <= slot + 5'd1;
      end
    end
  end

  // Both subframes of a frame are latched together at channel A slot 0.
  always_ff @(posedge clk1 or negedge nrst) begin
    if (!nrst) begin
      cur_l <= '0;
      cur_r <= '0;
      cur_v <= 1'b0;
      cur_c <= 1'b0;
    end else if (consume) begin
      cur_v <= !buf_full;
      cur_c <= cs_bit;
      if (buf_full) begin
        cur_l <= buf_l;
        cur_r <= buf_r;
      end else begin
`ifdef SPDIF_UNDERRUN_HOLD_EN
        cur_l <= cur_l;
        cur_r <= cur_r;
`else
        cur_l <= '0;
        cur_r <= '0;
`endif
      end
    end
  end

  always_ff @(posedge clk1 or negedge nrst) begin
    if (!nrst) underrun <= 1'b0;
    else if (underrun_evt) underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

  // Slots 4..27 form one 24-bit field with the sample MSB pinned to slot 27.
  always_comb begin
    word    = ch_b ? (24'(cur_r) << PAD) : (24'(cur_l) << PAD);
    cs_mask = CS_W'(1) << frame;
    cs_bit  = |(cs_bits & cs_mask);
    bit_d   = 1'b0;
    if (slot >= SLOT_AUX && slot < SLOT_V) begin
      bit_d = word[slot - SLOT_AUX];
    end else begin
      case (slot)
        SLOT_V:  bit_d = cur_v;
        SLOT_U:  bit_d = 1'b0;
        SLOT_C:  bit_d = cur_c;
        SLOT_P:  bit_d = par;
        default: bit_d = 1'b0;
      endcase
    end
    pre_d = ch_b ? PRE_W : ((frame == '0) ? PRE_B : PRE_M);
  end

  always_ff @(posedge clk1 or negedge nrst) begin
    if (!nrst) begin
      slot_valid <= 1'b0;
      slot_bit   <= 1'b0;
      slot_pre   <= 1'b0;
      pre_type   <= PRE_B;
      frame_idx  <= '0;
      par        <= 1'b0;
    end else begin
      slot_valid <= emit;
      if (emit) begin
        slot_bit  <= bit_d;
        slot_pre  <= (slot < SLOT_AUX);
        pre_type  <= pre_d;
        frame_idx <= frame;
        if (slot < SLOT_AUX)    par <= 1'b0;
        else if (slot != SLOT_P) par <= par ^ bit_d;
      end
    end
  end

endmodule

// File: tb/tb_spdif_frame_sequencer.sv
// Self-checking bench for spdif_frame_sequencer: random samples and strobe
// spacing checked slot by slot against a whole-subframe reference model.
module tb_spdif_frame_sequencer;

  localparam int WIDTH = 16;
  localparam int CS_W  = 32;

  logic             clk1 = 1'b0;
  logic             nrst;
  logic             bit_en;
  logic             en;
  logic [WIDTH-1:0] l_sample;
  logic [WIDTH-1:0] r_sample;
  logic             sample_valid;
  logic             sample_ready;
  logic [CS_W-1:0]  cs_bits;
  logic             slot_valid;
  logic             slot_bit;
  logic             slot_pre;
  logic [1:0]       pre_type;
  logic [7:0]       frame_idx;
  logic             underrun;
  logic             underrun_clr;

  always #5 clk1 = ~clk1;

  spdif_frame_sequencer #(.WIDTH(WIDTH), .CS_W(CS_W)) dut (
    .clk1         (clk1),
    .nrst         (nrst),
    .bit_en       (bit_en),
    .en           (en),
    .l_sample     (l_sample),
    .r_sample     (r_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .cs_bits      (cs_bits),
    .slot_valid   (slot_valid),
    .slot_bit     (slot_bit),
    .slot_pre     (slot_pre),
    .pre_type     (pre_type),
    .frame_idx    (frame_idx),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: n counts slots emitted since the sequencer last started.
  bit                 active;
  int                 n;
  bit                 feed;
  bit                 hold_full;
  logic [WIDTH-1:0]   hold_l, hold_r;
  logic [WIDTH-1:0]   fr_l, fr_r;
  bit                 fr_v, fr_c;
  bit                 m_underrun;
  logic [2*WIDTH-1:0] dir_q[$];

  function automatic logic [31:0] subframe(input logic [WIDTH-1:0] s, input bit v, input bit c);
    logic [31:0] w;
    w     = 32'(s) << (28 - WIDTH);
    w[28] = v;
    w[29] = 1'b0;
    w[30] = c;
    w[31] = ^w[30:4];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    active     = 1'b0;
    n          = 0;
    hold_full  = 1'b0;
    fr_l       = '0;
    fr_r       = '0;
    fr_v       = 1'b0;
    fr_c       = 1'b0;
    m_underrun = 1'b0;
  endtask

  // One clk1 cycle: drive inputs at negedge, predict, sample at next negedge.
  task automatic applyStimulus(input bit strobe);
    bit          exp_emit, exp_bit, exp_pre, chb, set_ur;
    logic [1:0]  exp_type;
    int          pos, slot, frame;
    logic [31:0] w;
    exp_emit = 1'b0; exp_bit = 1'b0; exp_pre = 1'b0; exp_type = 2'd0;
    frame = 0; set_ur = 1'b0;

    sample_valid = 1'b0;
    if (feed && sample_ready) begin
      if (dir_q.size() > 0) {l_sample, r_sample} = dir_q.pop_front();
      else begin
        l_sample = WIDTH'($urandom);
        r_sample = WIDTH'($urandom);
      end
      sample_valid = 1'b1;
    end
    bit_en = strobe;

    if (strobe) begin
      if (!active) begin
        if (en) active = 1'b1;
      end else begin
        pos   = n % 64;
        slot  = pos % 32;
        chb   = (pos >= 32);
        frame = (n / 64) % 192;
        if (pos == 0) begin
          if (hold_full) begin
            fr_l = hold_l; fr_r = hold_r; fr_v = 1'b0; hold_full = 1'b0;
          end else begin
            fr_v = 1'b1; set_ur = 1'b1;
`ifndef SPDIF_UNDERRUN_HOLD_EN
            fr_l = '0; fr_r = '0;
`endif
          end
          fr_c = (frame < CS_W) ? cs_bits[frame] : 1'b0;
        end
        w        = subframe(chb ? fr_r : fr_l, fr_v, fr_c);
        exp_emit = 1'b1;
        exp_bit  = w[slot];
        exp_pre  = (slot < 4);
        exp_type = chb ? 2'd2 : ((frame == 0) ? 2'd0 : 2'd1);
        n++;
        if (pos == 63 && !en) begin
          active = 1'b0;
          n      = 0;
        end
      end
    end
    if (sample_valid) begin
      hold_full = 1'b1; hold_l = l_sample; hold_r = r_sample;
    end
    if (set_ur) m_underrun = 1'b1;
    else if (underrun_clr) m_underrun = 1'b0;

    @(negedge clk1);
    bit_en = 1'b0;
    checkOutput("slot_valid", 32'(slot_valid), 32'(exp_emit));
    if (exp_emit) begin
      checkOutput("slot_bit", 32'(slot_bit), 32'(exp_bit));
      checkOutput("slot_pre", 32'(slot_pre), 32'(exp_pre));
      checkOutput("pre_type", 32'(pre_type), 32'(exp_type));
      checkOutput("frame_idx", 32'(frame_idx), 32'(frame));
    end
    checkOutput("sample_ready", 32'(sample_ready), 32'(!hold_full));
    checkOutput("underrun", 32'(underrun), 32'(m_underrun));
  endtask

  task automatic runSlot();
    if ($urandom_range(0, 1) == 1) applyStimulus(1'b0);
    applyStimulus(1'b1);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_slot_valid"}, 32'(slot_valid), 32'd0);
    checkOutput({tag, "_slot_bit"}, 32'(slot_bit), 32'd0);
    checkOutput({tag, "_slot_pre"}, 32'(slot_pre), 32'd0);
    checkOutput({tag, "_pre_type"}, 32'(pre_type), 32'd0);
    checkOutput({tag, "_frame_idx"}, 32'(frame_idx), 32'd0);
    checkOutput({tag, "_underrun"}, 32'(underrun), 32'd0);
    checkOutput({tag, "_sample_ready"}, 32'(sample_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nrst = 1'b1; bit_en = 1'b0; en = 1'b0; sample_valid = 1'b0;
    l_sample = '0; r_sample = '0; underrun_clr = 1'b0;
    cs_bits = 32'h0000_0005;
    feed = 1'b0;
    modelReset();
    #2 nrst = 1'b0;
    #1 checkReset("reset");
    repeat (2) @(negedge clk1);
    nrst = 1'b1;

    $display("[TB] first frame with L=A5A5 R=0001");
    dir_q.push_back({16'hA5A5, 16'h0001});
    feed = 1'b1;
    applyStimulus(1'b0);
    en = 1'b1;

    $display("[TB] 193 frames with samples always available");
    while (n < 192 * 64 + 3) runSlot();

    $display("[TB] underrun frame");
    while (n % 64 != 1) runSlot();
    feed = 1'b0;
    repeat (64) runSlot();
    feed = 1'b1;
    repeat (10) runSlot();
    checkOutput("underrun_set", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    applyStimulus(1'b0);
    underrun_clr = 1'b0;
    checkOutput("underrun_cleared", 32'(underrun), 32'd0);
    repeat (120) runSlot();

    $display("[TB] drop en at ch A slot 10");
    while (n % 64 != 11) runSlot();
    en = 1'b0;
    while (active) runSlot();
    repeat (5) applyStimulus(1'b1);
    en = 1'b1;
    repeat (70) runSlot();

    $display("[TB] reset at ch B slot 15");
    while (n % 64 != 48) runSlot();
    sample_valid = 1'b0;
    nrst = 1'b0;
    modelReset();
    #1 checkReset("midreset");
    @(negedge clk1);
    nrst = 1'b1;
    repeat (70) runSlot();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
